// File: rtl/axi4_burst_slave_ctrl.sv
// AXI4 burst slave controller in front of a single-port word RAM.
// FIXED/INCR/WRAP bursts up to 256 beats, byte strobes, 1-cycle RAM read
// latency absorbed by a 2-entry read FIFO, SLVERR on illegal bursts.
module axi4_burst_slave_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int RAM_DEPTH  = 256,
   localparam int MAW       = $clog2(RAM_DEPTH),
   localparam int BYTES     = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [BYTES-1:0]      s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [7:0]            s_axi_arlen,
   input  logic [1:0]            s_axi_arburst,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rlast,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  mem_en,
   output logic [BYTES-1:0]      mem_we,
   output logic [MAW-1:0]        mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int LSB = $clog2(BYTES);
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_BURST, R_DRAIN} r_state_t;

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic                  aw_hs, ar_hs, idle_both, pref_rd;
   logic [MAW-1:0]        w_idx, r_idx;
   logic [7:0]            w_len, w_cnt, r_len, r_issued, r_beat;
   logic [1:0]            w_burst, r_burst;
   logic                  w_err, w_last_err, r_err;
   logic                  w_beat, r_issue, r_pop, inflight;
   logic [1:0]            f_cnt;
   logic                  f_wp, f_rp;
   logic [2:0]            occ;
   logic [DATA_WIDTH-1:0] fifo [2];

   function automatic logic [MAW-1:0] next_idx(input logic [MAW-1:0] idx,
                                               input logic [1:0] burst,
                                               input logic [7:0] len);
      logic [MAW-1:0] mask, inc;
      mask = MAW'(len);
      inc  = idx + MAW'(1);
      case (burst)
         BURST_INCR: next_idx = inc;
         BURST_WRAP: next_idx = (idx & ~mask) | (inc & mask);
         default:    next_idx = idx;
      endcase
   endfunction

   function automatic logic burst_err(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [7:0] len,
                                      input logic [1:0] burst);
      logic bad_type, bad_wrap, bad_addr;
      bad_type  = (burst == 2'b11);
      bad_wrap  = (burst == BURST_WRAP) &&
                  !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      bad_addr  = (addr >> (LSB + MAW)) != '0;
      burst_err = bad_type | bad_wrap | bad_addr;
   endfunction

   assign aw_hs     = s_axi_awvalid && s_axi_awready;
   assign ar_hs     = s_axi_arvalid && s_axi_arready;
   assign idle_both = (w_state == W_IDLE) && (r_state == R_IDLE) &&
                      !s_axi_awready && !s_axi_arready;

   // Registered one-cycle grant pulses; contention alternates, write first.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_axi_awready <= 1'b0;
         s_axi_arready <= 1'b0;
         pref_rd       <= 1'b0;
      end else begin
         s_axi_awready <= 1'b0;
         s_axi_arready <= 1'b0;
         if (idle_both) begin
            if (s_axi_awvalid && s_axi_arvalid) begin
               s_axi_awready <= !pref_rd;
               s_axi_arready <= pref_rd;
               pref_rd       <= !pref_rd;
            end else if (s_axi_awvalid) begin
               s_axi_awready <= 1'b1;
            end else if (s_axi_arvalid) begin
               s_axi_arready <= 1'b1;
            end
         end
      end
   end

   // Write FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   // Write FSM next state and W/B channel outputs.
   always_comb begin
      w_next       = w_state;
      s_axi_wready = 1'b0;
      s_axi_bvalid = 1'b0;
      s_axi_bresp  = 2'b00;
      w_beat       = 1'b0;
      case (w_state)
         W_IDLE: if (aw_hs) w_next = W_DATA;
         W_DATA: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid) begin
               w_beat = 1'b1;
               if (w_cnt == w_len) w_next = W_RESP;
            end
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            s_axi_bresp  = {w_err | w_last_err, 1'b0};
            if (s_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // Write burst parameters, beat counter and wlast consistency tracking.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_idx <= '0; w_len <= '0; w_burst <= '0; w_cnt <= '0;
         w_err <= 1'b0; w_last_err <= 1'b0;
      end else if (aw_hs) begin
         w_idx      <= s_axi_awaddr[LSB+MAW-1:LSB];
         w_len      <= s_axi_awlen;
         w_burst    <= s_axi_awburst;
         w_cnt      <= '0;
         w_err      <= burst_err(s_axi_awaddr, s_axi_awlen, s_axi_awburst);
         w_last_err <= 1'b0;
      end else if (w_beat) begin
         w_cnt <= w_cnt + 8'd1;
         w_idx <= next_idx(w_idx, w_burst, w_len);
         if (s_axi_wlast != (w_cnt == w_len)) w_last_err <= 1'b1;
      end
   end

   // Read FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   // Read FSM next state, read issue throttling and R channel outputs.
   // Occupancy counts this cycle's pop so a full-rate stream never stalls.
   always_comb begin
      r_next       = r_state;
      r_issue      = 1'b0;
      s_axi_rvalid = (f_cnt != 2'd0);
      r_pop        = s_axi_rvalid && s_axi_rready;
      occ          = {1'b0, f_cnt} + {2'b00, inflight} - {2'b00, r_pop};
      s_axi_rdata  = s_axi_rvalid ? fifo[f_rp] : '0;
      s_axi_rresp  = s_axi_rvalid ? {r_err, 1'b0} : 2'b00;
      s_axi_rlast  = s_axi_rvalid && (r_beat == r_len);
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_BURST;
         R_BURST: if (occ < 3'd2) begin
            r_issue = 1'b1;
            if (r_issued == r_len) r_next = R_DRAIN;
         end
         R_DRAIN: if (r_pop && (r_beat == r_len)) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Read burst parameters, issue/accept counters and FIFO bookkeeping.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_idx <= '0; r_len <= '0; r_burst <= '0; r_err <= 1'b0;
         r_issued <= '0; r_beat <= '0;
         inflight <= 1'b0; f_cnt <= '0; f_wp <= 1'b0; f_rp <= 1'b0;
      end else begin
         if (ar_hs) begin
            r_idx    <= s_axi_araddr[LSB+MAW-1:LSB];
            r_len    <= s_axi_arlen;
            r_burst  <= s_axi_arburst;
            r_err    <= burst_err(s_axi_araddr, s_axi_arlen, s_axi_arburst);
            r_issued <= '0;
            r_beat   <= '0;
         end else begin
            if (r_issue) begin
               r_issued <= r_issued + 8'd1;
               r_idx    <= next_idx(r_idx, r_burst, r_len);
            end
            if (r_pop) r_beat <= r_beat + 8'd1;
         end
         inflight <= r_issue;
         f_cnt    <= f_cnt + {1'b0, inflight} - {1'b0, r_pop};
         if (inflight) f_wp <= !f_wp;
         if (r_pop)    f_rp <= !f_rp;
      end
   end

   // FIFO storage; erroneous bursts push zeros in place of RAM data.
   always_ff @(posedge aclk) begin
      if (inflight) fifo[f_wp] <= r_err ? '0 : mem_rdata;
   end

   // RAM port: the single owning burst drives it.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_beat && !w_err) begin
         mem_en    = 1'b1;
         mem_we    = s_axi_wstrb;
         mem_addr  = w_idx;
         mem_wdata = s_axi_wdata;
      end else if (r_issue && !r_err) begin
         mem_en   = 1'b1;
         mem_addr = r_idx;
      end
   end

endmodule
